// File: rtl/multicycle_data_path.sv
// multicycle_data_path: parametrised multi-cycle core datapath.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB.
// Instruction and data memories sit behind req/ready handshakes, so
// memories that insert wait states are supported. A HALT state is left
// only by reset. The retire output pulses once per completed instruction.
module multicycle_data_path #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int RA_W    = 3,
  parameter int INSTR_W = 4 + 2*RA_W + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               retire
);

  localparam int NREG = 1 << RA_W;
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_BZ   = 4'd11;
  localparam logic [3:0] OP_BC   = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd13;

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_regs [NREG];
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_d;
  logic [DATA_W-1:0]  r_result;
  logic               r_z;
  logic               r_c;
  logic [ADDR_W-1:0]  r_maddr;

  logic [3:0]         w_op;
  logic [RA_W-1:0]    w_rd;
  logic [RA_W-1:0]    w_rs;
  logic [RA_W-1:0]    w_rt;
  logic [ADDR_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_immd;
  logic [SH_W-1:0]    w_shamt;
  logic [DATA_W:0]    w_wide;
  logic [DATA_W:0]    w_shr;
  logic [DATA_W-1:0]  w_alu;
  logic               w_carry;
  logic               w_isAlu;
  logic               w_isMem;
  logic               w_taken;
  logic [ADDR_W-1:0]  w_aext;
  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W-1:0]  w_target;

  // Instruction fields are always decoded from the latched IR.
  assign w_op    = r_ir[INSTR_W-1 -: 4];
  assign w_rd    = r_ir[INSTR_W-5 -: RA_W];
  assign w_rs    = r_ir[INSTR_W-5-RA_W -: RA_W];
  assign w_imm   = r_ir[ADDR_W-1:0];
  assign w_rt    = w_imm[RA_W-1:0];
  assign w_immd  = w_imm[DATA_W-1:0];
  assign w_shamt = w_imm[SH_W-1:0];
  assign w_isAlu = (w_op[3] == 1'b0);
  assign w_isMem = (w_op == OP_LD) || (w_op == OP_ST);

  // ALU works one bit wider so the top bit carries carry, borrow or the
  // last bit shifted out; SHR shifts a zero-padded copy so bit 0 holds it.
  always_comb begin
    w_wide = '0;
    w_shr  = '0;
    case (w_op)
      OP_ADD:  w_wide = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_wide = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_wide = {1'b0, r_a & r_b};
      OP_OR:   w_wide = {1'b0, r_a | r_b};
      OP_ADDI: w_wide = {1'b0, r_a} + {1'b0, w_immd};
      OP_SUBI: w_wide = {1'b0, r_a} - {1'b0, w_immd};
      OP_SHL:  w_wide = {1'b0, r_a} << w_shamt;
      OP_SHR: begin
        w_shr  = {r_a, 1'b0} >> w_shamt;
        w_wide = {w_shr[0], w_shr[DATA_W:1]};
      end
      default: w_wide = '0;
    endcase
    w_alu   = w_wide[DATA_W-1:0];
    w_carry = w_wide[DATA_W];
  end

  // Address and branch arithmetic: zero-extended base for memory,
  // sign-extended offset relative to the already incremented pc.
  always_comb begin
    w_aext = '0;
    w_aext[DATA_W-1:0] = r_a;
    w_off = {ADDR_W{w_immd[DATA_W-1]}};
    w_off[DATA_W-1:0] = w_immd;
    w_taken = (w_op == OP_JMP) || ((w_op == OP_BZ) && r_z) ||
              ((w_op == OP_BC) && r_c);
    w_target = (w_op == OP_JMP) ? w_imm : (r_pc + w_off);
  end

  // Main sequencer: advances the FSM and owns all architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_maddr  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_pc    <= r_pc + 1'b1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_d     <= r_regs[w_rd];
          r_state <= (w_op == OP_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (w_isAlu) begin
            r_result <= w_alu;
            r_z      <= (w_alu == '0);
            r_c      <= w_carry;
            r_state  <= S_WB;
          end else if (w_isMem) begin
            r_maddr <= w_aext + w_imm;
            r_state <= S_MEM;
          end else begin
            if (w_taken) r_pc <= w_target;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (w_op == OP_LD) begin
              r_result <= dmem_rdata;
              r_state  <= S_WB;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          r_regs[w_rd] <= r_result;
          r_state      <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Handshake outputs and the retire strobe are decoded from state so
  // that they drop in the same instant reset is asserted.
  always_comb begin
    imem_req   = !rst && (r_state == S_FETCH);
    dmem_req   = !rst && (r_state == S_MEM);
    dmem_we    = dmem_req && (w_op == OP_ST);
    imem_addr  = r_pc;
    dmem_addr  = r_maddr;
    dmem_wdata = r_d;
    pc         = r_pc;
    halted     = (r_state == S_HALT);
    retire     = !rst && ((r_state == S_WB) ||
                          ((r_state == S_EXEC) && !w_isAlu && !w_isMem) ||
                          ((r_state == S_MEM) && (w_op == OP_ST) && dmem_ready));
  end

endmodule

// File: tb/tb_multicycle_data_path.sv
// tb_multicycle_data_path: directed tests for the multi-cycle core with
// behavioural instruction/data memories that can insert wait states.
module tb_multicycle_data_path;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 12;
  localparam int RA_W    = 3;
  localparam int INSTR_W = 4 + 2*RA_W + ADDR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [ADDR_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ready;
  logic [DATA_W-1:0]  dmem_rdata;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               retire;

  logic [INSTR_W-1:0] imem [0:4095];
  logic [DATA_W-1:0]  dmem [0:4095];
  logic [ADDR_W-1:0]  fetchLog [0:1023];
  int fetchCnt = 0;
  int iwait = 0;
  int dwait = 0;
  int icnt = 0;
  int dcnt = 0;
  int nChecks = 0;
  int nPass = 0;

  multicycle_data_path #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign imem_ready = imem_req && (icnt >= iwait);
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ready = dmem_req && (dcnt >= dwait);

  // Memory models: wait-state counters, store write port and fetch trace.
  always @(posedge clk) begin
    if (!imem_req || imem_ready) icnt <= 0; else icnt <= icnt + 1;
    if (!dmem_req || dmem_ready) dcnt <= 0; else dcnt <= dcnt + 1;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (imem_req && imem_ready) begin
      if (fetchCnt < 1024) fetchLog[fetchCnt] <= imem_addr;
      fetchCnt <= fetchCnt + 1;
    end
  end

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic [11:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Fill the instruction memory with HALT so stray fetches stop the core.
  task automatic clearProgram();
    for (int i = 0; i < 4096; i++) imem[i] = enc(4'd13, 3'd0, 3'd0, 12'h000);
    iwait = 0;
    dwait = 0;
  endtask

  // Reset for two cycles, release on a falling edge, end in cycle 1.
  task automatic resetCore();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic waitHalt(input int maxCyc, output bit done);
    int n;
    n = 0;
    while (!halted && n < maxCyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    done = halted;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    nChecks++;
    if (imem_req !== 1'b0) $display("[TB] FAIL reset_imem_req: got %b expected 0", imem_req);
    else nPass++;
    nChecks++;
    if (dmem_req !== 1'b0) $display("[TB] FAIL reset_dmem_req: got %b expected 0", dmem_req);
    else nPass++;
    nChecks++;
    if (pc !== 12'h000) $display("[TB] FAIL reset_pc: got %h expected 000", pc);
    else nPass++;
    nChecks++;
    if (halted !== 1'b0 || retire !== 1'b0)
      $display("[TB] FAIL reset_status: got halted=%b retire=%b expected 0 0", halted, retire);
    else nPass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nChecks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000)
      $display("[TB] FAIL reset_first_fetch: got req=%b addr=%h expected 1 000", imem_req, imem_addr);
    else nPass++;
  endtask

  task automatic test_alu_timing();
    logic [31:0] mask;
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h005);
    imem[1] = enc(4'd4, 3'd2, 3'd0, 12'h003);
    imem[2] = enc(4'd0, 3'd3, 3'd1, 12'h002);
    resetCore();
    mask = '0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (retire) mask[cyc] = 1'b1;
      @(negedge clk);
      #1;
    end
    waitHalt(20, done);
    nChecks++;
    if (mask !== 32'h0000_1110) $display("[TB] FAIL alu_retire_cycles: got %h expected 00001110", mask);
    else nPass++;
    nChecks++;
    if (dut.r_regs[3] !== 8'd8) $display("[TB] FAIL alu_add_r3: got %h expected 08", dut.r_regs[3]);
    else nPass++;
    nChecks++;
    if (dut.r_z !== 1'b0 || dut.r_c !== 1'b0)
      $display("[TB] FAIL alu_add_flags: got Z=%b C=%b expected 0 0", dut.r_z, dut.r_c);
    else nPass++;
  endtask

  task automatic test_flags();
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h0FF);
    imem[1] = enc(4'd4, 3'd1, 3'd1, 12'h001);
    resetCore();
    waitHalt(40, done);
    nChecks++;
    if (!done || dut.r_regs[1] !== 8'h00 || dut.r_z !== 1'b1 || dut.r_c !== 1'b1)
      $display("[TB] FAIL addi_overflow: got halt=%b r1=%h Z=%b C=%b expected 1 00 1 1",
               done, dut.r_regs[1], dut.r_z, dut.r_c);
    else nPass++;
    clearProgram();
    imem[0] = enc(4'd5, 3'd2, 3'd0, 12'h001);
    resetCore();
    waitHalt(40, done);
    nChecks++;
    if (!done || dut.r_regs[2] !== 8'hFF || dut.r_z !== 1'b0 || dut.r_c !== 1'b1)
      $display("[TB] FAIL subi_borrow: got halt=%b r2=%h Z=%b C=%b expected 1 ff 0 1",
               done, dut.r_regs[2], dut.r_z, dut.r_c);
    else nPass++;
  endtask

  task automatic test_logic_ops();
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h03C);
    imem[1] = enc(4'd4, 3'd2, 3'd0, 12'h00F);
    imem[2] = enc(4'd2, 3'd3, 3'd1, 12'h002);
    imem[3] = enc(4'd3, 3'd4, 3'd1, 12'h002);
    imem[4] = enc(4'd1, 3'd5, 3'd2, 12'h001);
    resetCore();
    waitHalt(60, done);
    nChecks++;
    if (!done || dut.r_regs[3] !== 8'h0C || dut.r_regs[4] !== 8'h3F)
      $display("[TB] FAIL and_or: got halt=%b r3=%h r4=%h expected 1 0c 3f",
               done, dut.r_regs[3], dut.r_regs[4]);
    else nPass++;
    nChecks++;
    if (dut.r_regs[5] !== 8'hD3 || dut.r_c !== 1'b1)
      $display("[TB] FAIL sub_borrow: got r5=%h C=%b expected d3 1", dut.r_regs[5], dut.r_c);
    else nPass++;
  endtask

  task automatic test_memory_wait();
    logic [31:0] mask;
    int reqCyc, weCyc, badAddr, badData;
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h02A);
    imem[1] = enc(4'd9, 3'd1, 3'd0, 12'h010);
    imem[2] = enc(4'd8, 3'd4, 3'd0, 12'h010);
    dwait = 3;
    resetCore();
    mask = '0;
    reqCyc = 0; weCyc = 0; badAddr = 0; badData = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (retire) mask[cyc] = 1'b1;
      if (dmem_req) begin
        reqCyc++;
        if (dmem_addr !== 12'h010) badAddr++;
        if (dmem_we) begin
          weCyc++;
          if (dmem_wdata !== 8'h2A) badData++;
        end
      end
      @(negedge clk);
      #1;
    end
    waitHalt(20, done);
    nChecks++;
    if (mask !== 32'h0008_0810) $display("[TB] FAIL mem_retire_cycles: got %h expected 00080810", mask);
    else nPass++;
    nChecks++;
    if (reqCyc !== 8 || weCyc !== 4)
      $display("[TB] FAIL mem_req_we_cycles: got req=%0d we=%0d expected 8 4", reqCyc, weCyc);
    else nPass++;
    nChecks++;
    if (badAddr !== 0 || badData !== 0)
      $display("[TB] FAIL mem_addr_data_stable: got badAddr=%0d badData=%0d expected 0 0", badAddr, badData);
    else nPass++;
    nChecks++;
    if (dut.r_regs[4] !== 8'h2A || dmem[12'h010] !== 8'h2A)
      $display("[TB] FAIL mem_load_store: got r4=%h mem=%h expected 2a 2a", dut.r_regs[4], dmem[12'h010]);
    else nPass++;
  endtask

  task automatic test_branches();
    int base, wraps, fffSeen;
    logic [ADDR_W-1:0] expFetch [0:4];
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h007);
    imem[1] = enc(4'd10, 3'd0, 3'd0, 12'h004);
    imem[2] = enc(4'd14, 3'd0, 3'd0, 12'h000);
    imem[4] = enc(4'd5, 3'd1, 3'd1, 12'h007);
    imem[5] = enc(4'd11, 3'd0, 3'd0, 12'h0FD);
    expFetch[0] = 12'h000; expFetch[1] = 12'h001; expFetch[2] = 12'h004;
    expFetch[3] = 12'h005; expFetch[4] = 12'h003;
    resetCore();
    base = fetchCnt;
    waitHalt(60, done);
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (fetchLog[base+i] !== expFetch[i])
        $display("[TB] FAIL bz_taken_fetch%0d: got %h expected %h", i, fetchLog[base+i], expFetch[i]);
      else nPass++;
    end
    nChecks++;
    if (!done || pc !== 12'h004) $display("[TB] FAIL bz_taken_pc: got halt=%b pc=%h expected 1 004", done, pc);
    else nPass++;

    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h007);
    for (int i = 1; i < 5; i++) imem[i] = enc(4'd14, 3'd0, 3'd0, 12'h000);
    imem[5] = enc(4'd11, 3'd0, 3'd0, 12'h0FD);
    resetCore();
    base = fetchCnt;
    waitHalt(60, done);
    nChecks++;
    if (fetchLog[base+6] !== 12'h006) $display("[TB] FAIL bz_not_taken: got fetch %h expected 006", fetchLog[base+6]);
    else nPass++;

    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h0FF);
    imem[1] = enc(4'd4, 3'd1, 3'd1, 12'h001);
    imem[2] = enc(4'd12, 3'd0, 3'd0, 12'h002);
    resetCore();
    waitHalt(60, done);
    nChecks++;
    if (!done || pc !== 12'h006) $display("[TB] FAIL bc_taken: got halt=%b pc=%h expected 1 006", done, pc);
    else nPass++;

    clearProgram();
    imem[0]      = enc(4'd5, 3'd6, 3'd5, 12'h002);
    imem[1]      = enc(4'd11, 3'd0, 3'd0, 12'h001);
    imem[2]      = enc(4'd10, 3'd0, 3'd0, 12'hFFF);
    imem[12'hFFF] = enc(4'd4, 3'd5, 3'd5, 12'h001);
    resetCore();
    base = fetchCnt;
    waitHalt(200, done);
    wraps = 0;
    fffSeen = 0;
    for (int i = base; i < fetchCnt - 1; i++) begin
      if (fetchLog[i] == 12'hFFF) fffSeen++;
      if (fetchLog[i] == 12'hFFF && fetchLog[i+1] == 12'h000) wraps++;
    end
    nChecks++;
    if (fffSeen !== 2 || wraps !== 2)
      $display("[TB] FAIL jmp_fetch_wrap: got fff=%0d wraps=%0d expected 2 2", fffSeen, wraps);
    else nPass++;
    nChecks++;
    if (!done || dut.r_regs[5] !== 8'h02 || pc !== 12'h004)
      $display("[TB] FAIL wrap_loop_result: got halt=%b r5=%h pc=%h expected 1 02 004", done, dut.r_regs[5], pc);
    else nPass++;
  endtask

  task automatic test_shifts();
    bit done;
    clearProgram();
    imem[0] = enc(4'd4, 3'd2, 3'd0, 12'h081);
    imem[1] = enc(4'd6, 3'd2, 3'd2, 12'h001);
    resetCore();
    waitHalt(40, done);
    nChecks++;
    if (!done || dut.r_regs[2] !== 8'h02 || dut.r_c !== 1'b1)
      $display("[TB] FAIL shl_by1: got halt=%b r2=%h C=%b expected 1 02 1", done, dut.r_regs[2], dut.r_c);
    else nPass++;
    clearProgram();
    imem[0] = enc(4'd4, 3'd2, 3'd0, 12'h081);
    imem[1] = enc(4'd4, 3'd3, 3'd0, 12'h0FF);
    imem[2] = enc(4'd4, 3'd3, 3'd3, 12'h001);
    imem[3] = enc(4'd7, 3'd2, 3'd2, 12'h000);
    imem[4] = enc(4'd7, 3'd4, 3'd2, 12'h001);
    resetCore();
    waitHalt(60, done);
    nChecks++;
    if (!done || dut.r_regs[2] !== 8'h81)
      $display("[TB] FAIL shr_by0: got halt=%b r2=%h expected 1 81", done, dut.r_regs[2]);
    else nPass++;
    nChecks++;
    if (dut.r_regs[4] !== 8'h40 || dut.r_c !== 1'b1)
      $display("[TB] FAIL shr_by1: got r4=%h C=%b expected 40 1", dut.r_regs[4], dut.r_c);
    else nPass++;
    clearProgram();
    imem[0] = enc(4'd4, 3'd3, 3'd0, 12'h0FF);
    imem[1] = enc(4'd4, 3'd3, 3'd3, 12'h001);
    imem[2] = enc(4'd7, 3'd2, 3'd2, 12'h000);
    resetCore();
    waitHalt(60, done);
    nChecks++;
    if (!done || dut.r_c !== 1'b0 || dut.r_z !== 1'b1)
      $display("[TB] FAIL shr_by0_clears_c: got halt=%b C=%b Z=%b expected 1 0 1", done, dut.r_c, dut.r_z);
    else nPass++;
  endtask

  task automatic test_halt_and_reset();
    int reqSeen;
    bit done;
    clearProgram();
    resetCore();
    waitHalt(20, done);
    reqSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req || retire) reqSeen++;
      stepCycles(1);
    end
    nChecks++;
    if (!done || halted !== 1'b1 || pc !== 12'h001 || reqSeen !== 0)
      $display("[TB] FAIL halt_quiet: got halted=%b pc=%h activity=%0d expected 1 001 0", halted, pc, reqSeen);
    else nPass++;

    clearProgram();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 12'h009);
    imem[1] = enc(4'd4, 3'd2, 3'd0, 12'h004);
    iwait = 3;
    resetCore();
    stepCycles(7);
    nChecks++;
    if (imem_req !== 1'b1 || dut.r_regs[1] !== 8'h09)
      $display("[TB] FAIL pre_reset_state: got req=%b r1=%h expected 1 09", imem_req, dut.r_regs[1]);
    else nPass++;
    rst = 1'b1;
    #1;
    nChecks++;
    if (imem_req !== 1'b0 || pc !== 12'h000 || dut.r_regs[1] !== 8'h00)
      $display("[TB] FAIL async_reset_drop: got req=%b pc=%h r1=%h expected 0 000 00", imem_req, pc, dut.r_regs[1]);
    else nPass++;
    @(negedge clk);
    iwait = 0;
    rst = 1'b0;
    #1;
    nChecks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000)
      $display("[TB] FAIL restart_fetch: got req=%b addr=%h expected 1 000", imem_req, imem_addr);
    else nPass++;
    waitHalt(40, done);
    nChecks++;
    if (!done || dut.r_regs[1] !== 8'h09 || dut.r_regs[2] !== 8'h04)
      $display("[TB] FAIL restart_program: got halt=%b r1=%h r2=%h expected 1 09 04",
               done, dut.r_regs[1], dut.r_regs[2]);
    else nPass++;
  endtask

  initial begin
    clearProgram();
    test_reset();
    test_alu_timing();
    test_flags();
    test_logic_ops();
    test_memory_wait();
    test_branches();
    test_shifts();
    test_halt_and_reset();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
